free_list: RTL and testbench
============================

# free_list

N-way circular free list of physical register tags for the R10K rename stage. Dispatch pops up to N free tags per cycle for new destinations. The reorder buffer pushes up to N retired `t_old` tags per cycle back into the list. It is the consumer of the ROB's retirement stream and the producer of `t` for ROB entries.

## Interface

Parameters:
- `N`, default 2: superscalar width (alloc and free lanes).
- `PHYS_REGS`, default 64: physical register count.
- `ARCH_REGS`, default 32: architectural register count.
- `DEPTH = PHYS_REGS - ARCH_REGS` (derived): list capacity. Must be a power of 2.

Ports:
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `num_alloc`  in  `$clog2(N+1)`: tags consumed by dispatch this cycle.
- `alloc_tags`  out  `N x $clog2(PHYS_REGS)`: next N tags from head, oldest in lane 0.
- `num_avail`  out  `$clog2(DEPTH+1)`: free tag count, registered.
- `free_valid`  in  N: retiring lanes carrying a tag to free.
- `free_tags`  in  `N x $clog2(PHYS_REGS)`: retired `t_old` tags.
- `ckpt_save`  in  1: snapshot head. Present only with `FREE_LIST_CHECKPOINT_EN`.
- `ckpt_restore`  in  1: roll head back to snapshot. Present only with `FREE_LIST_CHECKPOINT_EN`.

## Operation

- State:
  - `entries[DEPTH]` of tags.
  - `head` and `tail`, each `$clog2(DEPTH)` bits, wrapping naturally.
  - `count`, `$clog2(DEPTH+1)` bits.
- Reset values:
  - `entries[i] = ARCH_REGS + i`.
  - `head = 0`, `tail = 0`, `count = DEPTH`.
  - `num_avail = DEPTH`.
  - `alloc_tags[i] = ARCH_REGS + i`.
- Alloc:
  - `alloc_tags[i] = entries[head+i]`, combinational from registered state.
  - Lane i is meaningful only when `i < num_avail`.
  - Effective alloc = `min(num_alloc, num_avail)`. Overdemand is silently clamped.
  - `head += effective alloc`.
- Free:
  - Valid lanes are compacted in lane order. The k-th set bit of `free_valid` is written to `entries[tail+k]`.
  - `tail += popcount(free_valid)`.
  - Sparse valid patterns (e.g. `2'b10`) are legal.
- `count_next = count - alloc + freed`.
  - Simultaneous alloc and free in the same cycle are both applied.
  - Tags freed this cycle are not visible on `alloc_tags` until the next cycle. There is no bypass.
- Overflow (freeing beyond DEPTH) cannot occur in a correct pipeline. The list does not check for it. The bench flags it.
- Empty: `num_avail = 0`. Alloc is suppressed, `head` holds.
- Full: `num_avail = DEPTH`. Frees are still written, and the pipeline guarantees they cannot exceed the room left.

## Timing

- Alloc latency: 0. The tags shown are consumed at the same edge that `num_alloc` is sampled.
- Free latency: 1. A tag freed at edge E is allocatable after E.
- `num_avail` and head/tail update at posedge only.
- Reset mid-operation: all state returns to reset values at that edge. In-flight alloc and free are discarded.

## Configuration

- `FREE_LIST_CHECKPOINT_EN` defined:
  - `ckpt_save` latches `head` into `saved_head` (reset 0).
  - `ckpt_restore` sets `head = saved_head` and `count = tail - saved_head` as a DEPTH-modulo difference. The value DEPTH is recovered when the list is full, i.e. `tail == saved_head` with frees pending.
  - Restore takes priority over alloc in the same cycle; alloc is ignored.
  - Frees in the restore cycle are still applied, both to `tail` and to `count`.
  - Save and restore in the same cycle: restore wins, and the snapshot is unchanged.
- Not defined:
  - Ports and the `saved_head` register are absent.
  - Behaviour is otherwise identical.

## Structure

- Shared package `r10k_pkg` holds:
  - typedef `PHYS_TAG` (`logic [$clog2(PHYS_REGS)-1:0]`).
  - constants `PHYS_REGS`, `ARCH_REGS`.
- The ROB uses the same `PHYS_TAG` for `t` and `t_old`.
- One sub-module: `lane_compact`, which maps `free_valid[N]` to per-lane write offsets plus a popcount.

## Test plan

All scenarios use N=2, PHYS_REGS=64, ARCH_REGS=32.

1. Reset → `num_avail = 32`, `alloc_tags = {33, 32}` (lane 1, lane 0).
2. `num_alloc = 2` for 16 cycles → tags 32..63 appear in order and `num_avail` reaches 0. A further `num_alloc = 2` → `head` and `num_avail` unchanged.
3. From empty, `free_valid = 2'b10`, `free_tags[1] = 5` → next cycle `num_avail = 1`, `alloc_tags[0] = 5`. Same-cycle `alloc_tags` still shows the stale entry, confirming no bypass.
4. With `count = 10`, assert `num_alloc = 2` and free two tags each cycle for 20 cycles → `count` stays 10. Pointers wrap past 31, and freed tags reappear in FIFO order.
5. Checkpoint (macro on):
   - save at `head = 4`, alloc 2 per cycle for 3 cycles, then restore → `head = 4` and `num_avail` returns to its pre-alloc value.
   - `ckpt_restore` together with `num_alloc = 2` → alloc ignored.
6. Reset asserted while alloc and free are active → next cycle matches scenario 1.

Source files
------------

// File: rtl/r10k_pkg.sv
// rtl/r10k_pkg.sv - shared R10K rename types and machine constants
package r10k_pkg;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  typedef logic [$clog2(PHYS_REGS)-1:0] PHYS_TAG;
endpackage

// File: rtl/lane_compact.sv
// rtl/lane_compact.sv - per-lane write offsets and popcount for sparse free lanes
module lane_compact #(
  parameter int N     = 2,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic [N-1:0]            valid,
  output logic [N-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]        count
);
  // Each lane's offset is the number of valid lanes below it.
  always_comb begin
    count  = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = count;
      count     = count + CNT_W'(valid[i]);
    end
  end
endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - N-way circular free list of physical tags; FREE_LIST_CHECKPOINT_EN adds head snapshot/restore
module free_list #(
  parameter int N         = 2,
  parameter int PHYS_REGS = r10k_pkg::PHYS_REGS,
  parameter int ARCH_REGS = r10k_pkg::ARCH_REGS,
  localparam int DEPTH    = PHYS_REGS - ARCH_REGS,
  localparam int TAG_W    = $clog2(PHYS_REGS),
  localparam int NA_W     = $clog2(N+1),
  localparam int CNT_W    = $clog2(DEPTH+1),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NA_W-1:0]           num_alloc,
  output logic [N-1:0][TAG_W-1:0]   alloc_tags,
  output logic [CNT_W-1:0]          num_avail,
  input  logic [N-1:0]              free_valid,
  input  logic [N-1:0][TAG_W-1:0]   free_tags
`ifdef FREE_LIST_CHECKPOINT_EN
  ,
  input  logic                      ckpt_save,
  input  logic                      ckpt_restore
`endif
);
  logic [TAG_W-1:0] entries_q [DEPTH];
  logic [TAG_W-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, wr_idx;
  logic [CNT_W-1:0] count_q, count_d, req, eff, freed_c;
  logic [N-1:0][NA_W-1:0] free_off;
  logic [NA_W-1:0]  freed;

  lane_compact #(.N(N), .CNT_W(NA_W)) u_compact (
    .valid  (free_valid),
    .offset (free_off),
    .count  (freed)
  );

`ifdef FREE_LIST_CHECKPOINT_EN
  logic [PTR_W-1:0] saved_head_q, saved_head_d, diff;
  // Set when tail sits a full lap ahead of saved_head, so a zero difference means DEPTH.
  logic             wrap_q, wrap_d;
`endif

  always_comb begin
    entries_d = entries_q;
    wr_idx    = '0;
    req       = CNT_W'(num_alloc);
    eff       = (req > count_q) ? count_q : req;
    freed_c   = CNT_W'(freed);
    for (int i = 0; i < N; i++) begin
      wr_idx = tail_q + PTR_W'(free_off[i]);
      if (free_valid[i]) entries_d[wr_idx] = free_tags[i];
    end
    tail_d  = tail_q + PTR_W'(freed);
    head_d  = head_q + PTR_W'(eff);
    count_d = count_q - eff + freed_c;
`ifdef FREE_LIST_CHECKPOINT_EN
    diff         = tail_q - saved_head_q;
    saved_head_d = saved_head_q;
    wrap_d       = wrap_q | ((freed != '0) && (tail_d == saved_head_q));
    if (ckpt_restore) begin
      head_d  = saved_head_q;
      count_d = (((diff == '0) && wrap_q) ? CNT_W'(DEPTH) : CNT_W'(diff)) + freed_c;
    end else if (ckpt_save) begin
      saved_head_d = head_q;
      wrap_d       = ((count_q + freed_c) == CNT_W'(DEPTH));
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= TAG_W'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
`ifdef FREE_LIST_CHECKPOINT_EN
      saved_head_q <= '0;
      wrap_q       <= 1'b1;
`endif
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
`ifdef FREE_LIST_CHECKPOINT_EN
      saved_head_q <= saved_head_d;
      wrap_q       <= wrap_d;
`endif
    end
  end

  always_comb begin
    alloc_tags = '0;
    for (int i = 0; i < N; i++) alloc_tags[i] = entries_q[head_q + PTR_W'(i)];
  end

  assign num_avail = count_q;
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized queue-model bench for free_list
module tb_free_list;
  localparam int DEPTH = 32;
`ifdef FREE_LIST_CHECKPOINT_EN
  localparam bit CKPT = 1'b1;
`else
  localparam bit CKPT = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      num_alloc;
  logic [1:0][5:0] alloc_tags;
  logic [5:0]      num_avail;
  logic [1:0]      free_valid;
  logic [1:0][5:0] free_tags;
  logic            ckpt_save;
  logic            ckpt_restore;

  int checks = 0;
  int errors = 0;
  int mq[$];
  int cq[$];
  bit cvalid = 0;
  bit overflow_seen = 0;

  always #5 clock = ~clock;

  free_list #(.N(2), .PHYS_REGS(64), .ARCH_REGS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .num_alloc    (num_alloc),
    .alloc_tags   (alloc_tags),
    .num_avail    (num_avail),
    .free_valid   (free_valid),
    .free_tags    (free_tags)
`ifdef FREE_LIST_CHECKPOINT_EN
    ,
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore)
`endif
  );

  // Free list as a FIFO of tags; the checkpoint is the FIFO contents seen at save time.
  task automatic model_update();
    int f[$];
    int pre[$];
    int eff;
    bit rs, sv;
    rs = CKPT && ckpt_restore;
    sv = CKPT && ckpt_save;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back(32 + i);
      cq = mq;
      cvalid = 0;
      return;
    end
    for (int i = 0; i < 2; i++) if (free_valid[i]) f.push_back(int'(free_tags[i]));
    pre = mq;
    if (rs) begin
      mq = cq;
    end else begin
      eff = (int'(num_alloc) < mq.size()) ? int'(num_alloc) : mq.size();
      repeat (eff) void'(mq.pop_front());
      if (sv) begin
        cq = pre;
        cvalid = 1;
      end
    end
    foreach (f[k]) begin
      mq.push_back(f[k]);
      cq.push_back(f[k]);
    end
    if (cq.size() > DEPTH) cvalid = 0;
    if (mq.size() > DEPTH) overflow_seen = 1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    num_alloc = 0; free_valid = 0; free_tags = '0;
    ckpt_save = 0; ckpt_restore = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
    checks++;
    if (num_avail !== 6'd32) begin errors++; $display("FAIL reset_avail got %0d exp 32", num_avail); end
    checks++;
    if (alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33)
      begin errors++; $display("FAIL reset_tags got {%0d,%0d} exp {33,32}", alloc_tags[1], alloc_tags[0]); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 16; k++) begin
      num_alloc = 2; free_valid = 0;
      checks++;
      if (alloc_tags[0] !== 6'(32 + 2*k) || alloc_tags[1] !== 6'(33 + 2*k))
        begin errors++; $display("FAIL drain_tags k%0d got {%0d,%0d} exp {%0d,%0d}", k, alloc_tags[1], alloc_tags[0], 33+2*k, 32+2*k); end
      checks++;
      if (num_avail !== 6'(32 - 2*k)) begin errors++; $display("FAIL drain_avail k%0d got %0d exp %0d", k, num_avail, 32-2*k); end
      tick();
    end
    checks++;
    if (num_avail !== 6'd0) begin errors++; $display("FAIL drain_empty got %0d exp 0", num_avail); end
    num_alloc = 2; tick();
    checks++;
    if (num_avail !== 6'd0 || alloc_tags[0] !== 6'd32)
      begin errors++; $display("FAIL overdemand got avail %0d tag %0d exp 0/32", num_avail, alloc_tags[0]); end
  endtask

  task automatic test_no_bypass();
    num_alloc = 0; free_valid = 2'b10; free_tags[1] = 6'd5; free_tags[0] = 6'd17;
    #1;
    checks++;
    if (alloc_tags[0] !== 6'd32 || num_avail !== 6'd0)
      begin errors++; $display("FAIL bypass_stale got tag %0d avail %0d exp 32/0", alloc_tags[0], num_avail); end
    tick();
    free_valid = 0;
    checks++;
    if (num_avail !== 6'd1 || alloc_tags[0] !== 6'd5)
      begin errors++; $display("FAIL sparse_free got tag %0d avail %0d exp 5/1", alloc_tags[0], num_avail); end
  endtask

  task automatic test_steady();
    num_alloc = 0;
    while (mq.size() < 10) begin
      free_valid = (10 - mq.size() >= 2) ? 2'b11 : 2'b01;
      free_tags[0] = 6'($urandom_range(0, 63));
      free_tags[1] = 6'($urandom_range(0, 63));
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      num_alloc = 2; free_valid = 2'b11;
      free_tags[0] = 6'($urandom_range(0, 63));
      free_tags[1] = 6'($urandom_range(0, 63));
      checks++;
      if (num_avail !== 6'd10) begin errors++; $display("FAIL steady_avail k%0d got %0d exp 10", k, num_avail); end
      checks++;
      if (alloc_tags[0] !== 6'(mq[0]) || alloc_tags[1] !== 6'(mq[1]))
        begin errors++; $display("FAIL steady_tags k%0d got {%0d,%0d} exp {%0d,%0d}", k, alloc_tags[1], alloc_tags[0], mq[1], mq[0]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int eff, room;
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      num_alloc = 2'($urandom_range(0, 2));
      if (CKPT) begin
        ckpt_save = ($urandom_range(0, 7) == 0);
        ckpt_restore = cvalid && ($urandom_range(0, 9) == 0);
      end
      eff = (int'(num_alloc) < mq.size()) ? int'(num_alloc) : mq.size();
      room = ckpt_restore ? DEPTH - cq.size() : DEPTH - (mq.size() - eff);
      free_valid = 2'($urandom_range(0, 3));
      if (room <= 0) free_valid = 0;
      else if (room == 1 && free_valid == 2'b11) free_valid = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      free_tags[0] = 6'($urandom_range(0, 63));
      free_tags[1] = 6'($urandom_range(0, 63));
      checks++;
      if (num_avail !== 6'(mq.size())) begin errors++; $display("FAIL rand_avail k%0d got %0d exp %0d", k, num_avail, mq.size()); end
      for (int i = 0; i < 2; i++) begin
        if (i < mq.size()) begin
          checks++;
          if (alloc_tags[i] !== 6'(mq[i]))
            begin errors++; $display("FAIL rand_tag k%0d lane%0d got %0d exp %0d", k, i, alloc_tags[i], mq[i]); end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_checkpoint();
    idle_inputs();
    reset = 1; tick(); reset = 0;
    num_alloc = 2; tick(); tick();
    num_alloc = 0; ckpt_save = 1; tick(); ckpt_save = 0;
    num_alloc = 2; tick(); tick(); tick();
    checks++;
    if (num_avail !== 6'd22) begin errors++; $display("FAIL ckpt_alloc got %0d exp 22", num_avail); end
    num_alloc = 0; ckpt_restore = 1; tick();
    checks++;
    if (alloc_tags[0] !== 6'd36 || num_avail !== 6'd28)
      begin errors++; $display("FAIL ckpt_restore got tag %0d avail %0d exp 36/28", alloc_tags[0], num_avail); end
    num_alloc = 2; ckpt_restore = 1; tick();
    checks++;
    if (alloc_tags[0] !== 6'd36 || num_avail !== 6'd28 || num_avail !== 6'(mq.size()))
      begin errors++; $display("FAIL ckpt_prio got tag %0d avail %0d exp 36/28", alloc_tags[0], num_avail); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      num_alloc = 2; free_valid = 2'b11;
      free_tags[0] = 6'($urandom_range(0, 63));
      free_tags[1] = 6'($urandom_range(0, 63));
      tick();
    end
    reset = 1; tick(); reset = 0;
    idle_inputs();
    checks++;
    if (num_avail !== 6'd32) begin errors++; $display("FAIL midreset_avail got %0d exp 32", num_avail); end
    checks++;
    if (alloc_tags[0] !== 6'd32 || alloc_tags[1] !== 6'd33)
      begin errors++; $display("FAIL midreset_tags got {%0d,%0d} exp {33,32}", alloc_tags[1], alloc_tags[0]); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    test_reset();
    test_drain();
    test_no_bypass();
    test_steady();
    test_random();
    if (CKPT) test_checkpoint();
    test_random();
    test_reset_mid();
    checks++;
    if (overflow_seen !== 1'b0) begin errors++; $display("FAIL overflow got %0d exp 0", overflow_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
